// File: rtl/ram_sync_clr.sv
// ram_sync_clr: synchronous single-port RAM with registered read,
// read-valid strobe and a built-in sequencer that zeroes every word.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high; starts a clear pass
//   cs       chip select, active-low
//   rw       1 = write, 0 = read (sampled when cs = 0)
//   adrs     word address
//   data_in  write data
//   clr      one-cycle request to re-run the clear pass
//   data_out registered read data, changes only on read or reset
//   rd_valid one-cycle strobe, data_out updated this cycle
//   busy     clear pass in progress, port accesses are ignored

module ram_sync_clr #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rw,
  input  logic [ADDR_W-1:0] adrs,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_we;
  logic              clr_last;
  logic              clr_req;
  logic              access;
  logic              wr_en;
  logic              rd_en;

  assign clr_we   = (state_q == CLEAR);
  assign clr_last = (clr_ptr == {ADDR_W{1'b1}});

  // A clear request in READY outranks a same-cycle access.
  assign clr_req  = (state_q == READY) && clr;
  assign access   = (state_q == READY) && !clr && !cs;
  assign wr_en    = access && rw;
  assign rd_en    = access && !rw;

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: begin
        if (clr_last) begin
          state_d = READY;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLEAR;
      clr_ptr  <= '0;
      busy     <= 1'b1;
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d == CLEAR);
      rd_valid <= rd_en;
      if (rd_en) begin
        data_out <= mem[adrs];
      end
      // Pointer wraps to zero on its own after the last word.
      if (clr_req) begin
        clr_ptr <= '0;
      end else if (clr_we) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  // Contents survive reset; only the clear pass zeroes them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_ptr] <= '0;
      end else if (wr_en) begin
        mem[adrs] <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_ram_sync_clr.sv
// tb_ram_sync_clr: scoreboard bench for ram_sync_clr (4x16).
// Read expectations queue on request, pop on rd_valid.

module tb_ram_sync_clr;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       rw;
  logic [3:0] adrs;
  logic [3:0] data_in;
  logic       clr;
  logic [3:0] data_out;
  logic       rd_valid;
  logic       busy;

  int n_cmp;
  int n_bad;

  logic [3:0] mmem [16];
  logic [3:0] mdout;
  logic [3:0] mptr;
  logic       mclear;
  logic       exp_rv;
  logic [3:0] sb [$];
  logic [3:0] wdat [16];

  ram_sync_clr #(.DATA_W(4), .ADDR_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .cs(cs),
    .rw(rw),
    .adrs(adrs),
    .data_in(data_in),
    .clr(clr),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w,
                      input logic [3:0] a, input logic [3:0] d,
                      input logic k);
    @(negedge clk);
    rst = r; cs = c; rw = w; adrs = a; data_in = d; clr = k;
    exp_rv = 1'b0;
    if (r) begin
      mclear = 1'b1;
      mptr = '0;
      mdout = '0;
      sb.delete();
    end else if (mclear) begin
      mmem[mptr] = '0;
      if (mptr == 4'hf) mclear = 1'b0;
      mptr = mptr + 4'd1;
    end else if (k) begin
      mclear = 1'b1;
      mptr = '0;
    end else if (!c) begin
      if (w) begin
        mmem[a] = d;
      end else begin
        sb.push_back(mmem[a]);
        mdout = mmem[a];
        exp_rv = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("busy", busy, mclear);
    chk("rd_valid", rd_valid, exp_rv);
    if (rd_valid) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else chk("rdata", data_out, sb.pop_front());
    end else begin
      if (exp_rv) void'(sb.pop_front());
      chk("hold", data_out, mdout);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
  endtask

  // Counts busy cycles, starting with the one already observed.
  task automatic wait_clear(input string tag);
    int n;
    n = 1;
    for (int i = 0; i < 64; i++) begin
      idle();
      if (busy) n++;
      else break;
    end
    chk(tag, n, 16);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'(i), 4'h0, 1'b0);
    end
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; cs = 1'b1; rw = 1'b0;
    adrs = '0; data_in = '0; clr = 1'b0;
    mclear = 1'b0; mptr = '0; mdout = '0;
    for (int i = 0; i < 16; i++) mmem[i] = '0;

    // reset, full clear pass, all words read zero
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    chk("rst_dout", data_out, 4'h0);
    wait_clear("busy_len_rst");
    read_all();

    // deselected writes must not land
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 4'(i), 4'ha, 1'b0);
    end
    read_all();

    // random fill and in-order readback
    for (int i = 0; i < 16; i++) begin
      wdat[i] = 4'($urandom_range(15));
      step(1'b0, 1'b0, 1'b1, 4'(i), wdat[i], 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'(i), 4'h0, 1'b0);
      chk("fill", data_out, wdat[i]);
    end
    idle();

    // write then read same address back-to-back
    step(1'b0, 1'b0, 1'b1, 4'h3, 4'h5, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0);
    chk("wr_rd_fwd", data_out, 4'h5);

    // clr with read in the same cycle: clr wins
    step(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b1);
    chk("clr_drop", rd_valid, 1'b0);
    wait_clear("busy_len_clr");
    read_all();

    // refill, then rst in the middle of a pass
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 4'(i), 4'(15 - i), 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      // clr during CLEAR is ignored
      step(1'b0, 1'b0, 1'b0, 4'h1, 4'h0, (i == 2));
    end
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    wait_clear("busy_len_rst2");
    read_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
